cvt_fp_sd: RTL and testbench
============================

# cvt_fp_sd

Sequential IEEE-754 precision converter for the FPU datapath: implements cvt.d.s (single to double) and cvt.s.d (double to single) over the 32-bit FP register-file port. Doubles travel as even/odd register pairs, low word first. The block collects input words, converts them, then emits output words, using valid/ready handshakes on both sides. It sits beside the word/float converter and uses the same special-value policy: denormals flush to zero, and inf/NaN are flagged.

## Interface
- Parameters:
- EXPS, 8, single exponent width
- MANTS, 23, single fraction width
- EXPD, 11, double exponent width
- MANTD, 52, double fraction width (EXPD+MANTD+1 must equal 64, else elaboration error)
- Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- diA  in  32  input word
- ciWay  in  1  0 = widen (s→d), 1 = narrow (d→s); sampled with the first word of a transaction only
- ciValid  in  1  diA valid
- coReady  out  1  block accepts diA this cycle
- doY  out  32  output word
- coValid  out  1  doY valid
- ciReady  in  1  consumer accepts doY
- doNAN  out  1  result is NaN; valid while coValid is high
- doINF  out  1  result is ±inf (input inf, or overflow on narrow); valid while coValid is high

## Operation
- FSM states:
- IDLE: coReady=1. On ciValid, capture diA and ciWay. Go to CONV if ciWay=0, else RX_HI.
- RX_HI: coReady=1. On ciValid, capture the high word, then go to CONV.
- CONV: one cycle. Compute the result into output registers. Next state is TX_LO if ciWay=0, else TX_S.
- TX_LO: coValid=1, doY = low word. On ciReady go to TX_HI.
- TX_HI: coValid=1, doY = high word. On ciReady go to IDLE.
- TX_S: coValid=1, doY = single result. On ciReady go to IDLE.
- coReady is 0 in CONV and all TX states. No new transaction overlaps output.
- Widen (s→d):
- Sign is copied.
- exp=0: output signed zero (denormals are flushed).
- exp=255: output exp 2047, frac = frac<<29; doNAN = (frac≠0), doINF = (frac=0).
- Otherwise: exp+896, frac<<29. Exact conversion, no rounding.
- Narrow (d→s):
- exp=2047, frac≠0: output NaN with frac = frac[51:29], forced to 0x400000 if that is zero; doNAN=1.
- exp=2047, frac=0: output ±inf, doINF=1.
- exp=0: output signed zero.
- Otherwise: e = exp−896 (signed, 12-bit); m = {1,frac[51:29]}.
- Rounding: round half away from zero on the magnitude. Add 1 to m when frac[28]=1. A carry out gives m=0x800000 and e+1.
- e ≥ 255 after rounding: output ±inf (0x7F800000 | sign), doINF=1.
- e ≤ 0: output signed zero.
- Flags hold for every output word of the transaction. They clear in IDLE.

## Timing
- Reset values: state IDLE, coReady=1, coValid=0, doY=0, doNAN=0, doINF=0. Reset is asynchronous, so it clears the state immediately from any state.
- Transfer rule: a transfer occurs on a rising edge where valid && ready are both high.
- Output hold: doY and the flags are registered and stay stable while coValid=1 and ciReady=0.
- Widen latency, with ciReady held at 1:
- Cycle 0: word accepted.
- Cycle 1: CONV.
- Cycle 2: low word out.
- Cycle 3: high word out.
- Cycle 4: IDLE.
- Narrow latency:
- Cycle 0: low word accepted.
- Cycle 1: high word accepted (earliest).
- Cycle 2: CONV.
- Cycle 3: single result out.
- Gaps in ciValid during RX_HI stall the transaction indefinitely.
- Reset mid-operation: any partial pair or pending output is discarded. The next accepted word starts a new transaction.

## Configuration
- CVT_FP_SD_RNE_EN defined: narrow rounding is round-to-nearest-even. Increment m when frac[28]=1 and (frac[27:0]≠0 or m[0]=1).
- CVT_FP_SD_RNE_EN undefined (default): round half away from zero, as specified above.
- Widening is unaffected by the macro.

## Test plan
- Widen 1.0: diA=0x3F800000, ciWay=0 → lo 0x00000000, hi 0x3FF00000, flags 0. Also widen 0x80000000 → lo 0x00000000, hi 0x80000000.
- Narrow 1.0: lo 0x00000000, hi 0x3FF00000, ciWay=1 → 0x3F800000, output at cycle 3 after the first accept.
- Narrow halfway case: lo 0x10000000, hi 0x3FF00000 → 0x3F800001 by default; 0x3F800000 with CVT_FP_SD_RNE_EN.
- Narrow overflow: lo 0, hi 0x47F00000 (2^128) → 0x7F800000 with doINF=1. Narrow 0xC7F00000 → 0xFF800000 with doINF=1.
- NaN/inf widen: 0x7FC00000 → hi 0x7FF80000, lo 0, doNAN=1. 0xFF800000 → hi 0xFFF00000, lo 0, doINF=1. Denormal 0x00000001 → 0/0.
- Backpressure and reset:
- Hold ciReady=0 for 5 cycles in TX_LO → doY stays constant and coReady=0.
- Assert reset while in RX_HI → coValid=0 and coReady=1 immediately.
- Then send 0x3F800000 with ciWay=0 → a widen result appears normally.

Source files
------------

// File: rtl/cvt_fp_sd.sv
// ============================================================================
// Module   : cvt_fp_sd
// Purpose  : Sequential single<->double IEEE-754 converter over a 32-bit port.
//            Define CVT_FP_SD_RNE_EN to make narrowing round-to-nearest-even.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cvt_fp_sd #(
    parameter int EXPS  = 8,
    parameter int MANTS = 23,
    parameter int EXPD  = 11,
    parameter int MANTD = 52
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] diA,
    input  logic        ciWay,
    input  logic        ciValid,
    output logic        coReady,
    output logic [31:0] doY,
    output logic        coValid,
    input  logic        ciReady,
    output logic        doNAN,
    output logic        doINF
);

    localparam int c_SHIFT = MANTD - MANTS;
    localparam logic [EXPD-1:0] c_BIAS_DIFF = EXPD'((1 << (EXPD - 1)) - (1 << (EXPS - 1)));
    localparam logic signed [EXPD:0] c_SEXP_MAX = (EXPD + 1)'((1 << EXPS) - 1);

    generate
        if ((EXPD + MANTD + 1 != 64) || (EXPS + MANTS + 1 != 32)) begin : g_badWidth
            $error("cvt_fp_sd: format widths must total 32 (single) and 64 (double)");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX_HI = 3'd1,
        S_CONV  = 3'd2,
        S_TX_LO = 3'd3,
        S_TX_HI = 3'd4,
        S_TX_S  = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_way;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [31:0] r_outHi;

    // Widening: exact, the single sits in r_lo
    logic             w_sSign;
    logic [EXPS-1:0]  w_sExp;
    logic [MANTS-1:0] w_sFrac;
    logic [63:0]      w_wide;
    logic             w_wNan;
    logic             w_wInf;

    assign w_sSign = r_lo[31];
    assign w_sExp  = r_lo[MANTS +: EXPS];
    assign w_sFrac = r_lo[MANTS-1:0];

    always_comb begin
        w_wide = {w_sSign, 63'b0};
        w_wNan = 1'b0;
        w_wInf = 1'b0;
        if (w_sExp == '1) begin
            w_wide = {w_sSign, {EXPD{1'b1}}, w_sFrac, {c_SHIFT{1'b0}}};
            w_wNan = (w_sFrac != '0);
            w_wInf = (w_sFrac == '0);
        end else if (w_sExp != '0) begin
            w_wide = {w_sSign, {{(EXPD - EXPS){1'b0}}, w_sExp} + c_BIAS_DIFF,
                      w_sFrac, {c_SHIFT{1'b0}}};
        end
    end

    // Narrowing: rounding on the magnitude, then range check on the rebiased exponent
    logic [63:0]            w_dbl;
    logic                   w_dSign;
    logic [EXPD-1:0]        w_dExp;
    logic [MANTD-1:0]       w_dFrac;
    logic [MANTS:0]         w_mant;
    logic                   w_inc;
    logic [MANTS+1:0]       w_mantSum;
    logic signed [EXPD:0]   w_eRnd;
    logic [MANTS-1:0]       w_nanPay;
    logic [31:0]            w_narrow;
    logic                   w_nNan;
    logic                   w_nInf;

    assign w_dbl    = {r_hi, r_lo};
    assign w_dSign  = w_dbl[63];
    assign w_dExp   = w_dbl[MANTD +: EXPD];
    assign w_dFrac  = w_dbl[MANTD-1:0];
    assign w_mant   = {1'b1, w_dFrac[MANTD-1 -: MANTS]};
    assign w_nanPay = w_dFrac[MANTD-1 -: MANTS];

`ifdef CVT_FP_SD_RNE_EN
    assign w_inc = w_dFrac[c_SHIFT-1] & ((|w_dFrac[c_SHIFT-2:0]) | w_mant[0]);
`else
    assign w_inc = w_dFrac[c_SHIFT-1];
`endif

    assign w_mantSum = {1'b0, w_mant} + {{(MANTS + 1){1'b0}}, w_inc};
    assign w_eRnd    = $signed({1'b0, w_dExp}) - $signed({1'b0, c_BIAS_DIFF})
                     + $signed({{EXPD{1'b0}}, w_mantSum[MANTS+1]});

    always_comb begin
        w_narrow = {w_dSign, 31'b0};
        w_nNan   = 1'b0;
        w_nInf   = 1'b0;
        if (w_dExp == '1) begin
            if (w_dFrac != '0) begin
                w_narrow = {w_dSign, {EXPS{1'b1}},
                            (w_nanPay == '0) ? {1'b1, {(MANTS - 1){1'b0}}} : w_nanPay};
                w_nNan   = 1'b1;
            end else begin
                w_narrow = {w_dSign, {EXPS{1'b1}}, {MANTS{1'b0}}};
                w_nInf   = 1'b1;
            end
        end else if (w_dExp != '0) begin
            if (w_eRnd >= c_SEXP_MAX) begin
                w_narrow = {w_dSign, {EXPS{1'b1}}, {MANTS{1'b0}}};
                w_nInf   = 1'b1;
            end else if (w_eRnd > 0) begin
                // after a carry the sum is 1.000.., so its low bits are the fraction either way
                w_narrow = {w_dSign, w_eRnd[EXPS-1:0], w_mantSum[MANTS-1:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_way   <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_outHi <= '0;
            coReady <= 1'b1;
            coValid <= 1'b0;
            doY     <= '0;
            doNAN   <= 1'b0;
            doINF   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    doNAN <= 1'b0;
                    doINF <= 1'b0;
                    if (ciValid) begin
                        r_lo  <= diA;
                        r_way <= ciWay;
                        if (ciWay) begin
                            r_state <= S_RX_HI;
                        end else begin
                            r_state <= S_CONV;
                            coReady <= 1'b0;
                        end
                    end
                end
                S_RX_HI: begin
                    if (ciValid) begin
                        r_hi    <= diA;
                        r_state <= S_CONV;
                        coReady <= 1'b0;
                    end
                end
                S_CONV: begin
                    coValid <= 1'b1;
                    if (r_way) begin
                        doY     <= w_narrow;
                        doNAN   <= w_nNan;
                        doINF   <= w_nInf;
                        r_state <= S_TX_S;
                    end else begin
                        doY     <= w_wide[31:0];
                        r_outHi <= w_wide[63:32];
                        doNAN   <= w_wNan;
                        doINF   <= w_wInf;
                        r_state <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (ciReady) begin
                        doY     <= r_outHi;
                        r_state <= S_TX_HI;
                    end
                end
                S_TX_HI, S_TX_S: begin
                    if (ciReady) begin
                        coValid <= 1'b0;
                        coReady <= 1'b1;
                        doY     <= '0;
                        doNAN   <= 1'b0;
                        doINF   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cvt_fp_sd.sv
// ============================================================================
// Module   : tb_cvt_fp_sd
// Purpose  : Scoreboard bench for cvt_fp_sd against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cvt_fp_sd;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] diA;
    logic        ciWay;
    logic        ciValid;
    logic        coReady;
    logic [31:0] doY;
    logic        coValid;
    logic        ciReady;
    logic        doNAN;
    logic        doINF;

    cvt_fp_sd dut (
        .clk     (clk),
        .reset   (reset),
        .diA     (diA),
        .ciWay   (ciWay),
        .ciValid (ciValid),
        .coReady (coReady),
        .doY     (doY),
        .coValid (coValid),
        .ciReady (ciReady),
        .doNAN   (doNAN),
        .doINF   (doINF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        bit          nan;
        bit          inf;
    } exp_t;

    exp_t q[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   cyc    = 0;
    int   firstValidCyc = -1;
    bit   prevValid = 1'b0;
    bit   rdyRandom = 1'b0;
    bit   rdyForce  = 1'b1;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Reference: widening is value-preserving; rebias the exponent from 127 to 1023
    function automatic void modelWiden(input logic [31:0] s);
        exp_t        lo, hi;
        int          e = int'(s[30:23]);
        logic [63:0] d;
        bit          nan = 0, inf = 0;
        if (e == 0) d = {s[31], 63'b0};
        else if (e == 255) begin
            d = {s[31], 11'h7FF, s[22:0], 29'b0};
            nan = (s[22:0] != 0);
            inf = (s[22:0] == 0);
        end else begin
            d = {s[31], 11'((e - 127) + 1023), s[22:0], 29'b0};
        end
        lo = '{d[31:0], nan, inf};
        hi = '{d[63:32], nan, inf};
        q.push_back(lo);
        q.push_back(hi);
    endfunction

    // Reference: narrow via integer significand division by 2^29 with rounding
    function automatic void modelNarrow(input logic [31:0] hw, input logic [31:0] lw);
        logic [63:0]     d = {hw, lw};
        bit              sg = d[63];
        int              e = int'(d[62:52]);
        longint unsigned f = longint'(d[51:0]);
        longint unsigned sig, qt, rem, half, p;
        int              be;
        exp_t            r;
        r = '{{sg, 31'b0}, 1'b0, 1'b0};
        if (e == 2047) begin
            if (f != 0) begin
                p = f >> 29;
                if (p == 0) p = 64'h400000;
                r = '{{sg, 8'hFF, p[22:0]}, 1'b1, 1'b0};
            end else begin
                r = '{{sg, 8'hFF, 23'h0}, 1'b0, 1'b1};
            end
        end else if (e != 0) begin
            sig  = (64'd1 << 52) | f;
            qt   = sig >> 29;
            rem  = sig % (64'd1 << 29);
            half = 64'd1 << 28;
`ifdef CVT_FP_SD_RNE_EN
            if (rem > half || (rem == half && qt[0])) qt++;
`else
            if (rem >= half) qt++;
`endif
            be = (e - 1023) + 127;
            if (qt == (64'd1 << 24)) begin
                qt = qt >> 1;
                be++;
            end
            if (be >= 255) r = '{{sg, 8'hFF, 23'h0}, 1'b0, 1'b1};
            else if (be > 0) r = '{{sg, 8'(be), qt[22:0]}, 1'b0, 1'b0};
        end
        q.push_back(r);
    endfunction

    // Monitor: pops the scoreboard on every output transfer
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prevValid = 1'b0;
            end else begin
                if (coValid && !prevValid) firstValidCyc = cyc;
                prevValid = coValid;
                if (coValid && ciReady) begin
                    if (q.size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("FAIL unexpected_output: got %h, expected none", doY);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("output", {30'b0, doY, doNAN, doINF}, {30'b0, e.w, e.nan, e.inf});
                    end
                end
            end
        end
    end

    initial begin
        ciReady = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ciReady = rdyRandom ? ($urandom_range(0, 3) != 0) : rdyForce;
        end
    end

    task automatic sendWord(input logic [31:0] w, input logic way, output int c);
        int t = 0;
        @(negedge clk);
        diA = w;
        ciWay = way;
        ciValid = 1'b1;
        while (!coReady && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            nTests++;
            nFail++;
            $display("FAIL send_timeout: got coReady=0, expected coReady=1");
        end
        c = cyc;
        @(posedge clk);
        #1 ciValid = 1'b0;
    endtask

    task automatic doWiden(input logic [31:0] s, output int c);
        modelWiden(s);
        sendWord(s, 1'b0, c);
    endtask

    task automatic doNarrow(input logic [31:0] hw, input logic [31:0] lw, input int gap, output int c);
        int c2;
        modelNarrow(hw, lw);
        sendWord(lw, 1'b1, c);
        repeat (gap) @(negedge clk);
        sendWord(hw, 1'($urandom_range(0, 1)), c2);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || coValid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            nTests++;
            nFail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
    endtask

    task automatic waitValid();
        int t = 0;
        while (!coValid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            nTests++;
            nFail++;
            $display("FAIL valid_timeout: got coValid=0, expected 1");
        end
    endtask

    logic [31:0] widenIn  [5] = '{32'h3F800000, 32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h00000001};
    logic [31:0] narrowHi [4] = '{32'h3FF00000, 32'h3FF00000, 32'h47F00000, 32'hC7F00000};
    logic [31:0] narrowLo [4] = '{32'h00000000, 32'h10000000, 32'h00000000, 32'h00000000};

    initial begin
        int c;
        reset   = 1'b1;
        diA     = '0;
        ciWay   = 1'b0;
        ciValid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {27'b0, coReady, coValid, doNAN, doINF, doY},
              {27'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        #2 reset = 1'b0;

        // Latency with the consumer always ready
        drain();
        firstValidCyc = -1;
        doWiden(32'h3F800000, c);
        waitValid();
        check("widen_latency", 64'(firstValidCyc - c), 64'd2);
        drain();
        firstValidCyc = -1;
        doNarrow(32'h3FF00000, 32'h0, 0, c);
        waitValid();
        check("narrow_latency", 64'(firstValidCyc - c), 64'd3);
        drain();

        foreach (widenIn[i]) doWiden(widenIn[i], c);
        foreach (narrowHi[i]) doNarrow(narrowHi[i], narrowLo[i], i, c);
        drain();

        // Backpressure holds the low word
        rdyForce = 1'b0;
        @(negedge clk);
        doWiden(32'h40490FDB, c);
        waitValid();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_doY", {32'b0, doY}, {32'b0, q[0].w});
            check("bp_coReady", {63'b0, coReady}, 64'd0);
            @(negedge clk);
        end
        rdyForce = 1'b1;
        drain();

        // Reset while waiting for the high word
        sendWord(32'h12345678, 1'b1, c);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rst_rxhi", {62'b0, coValid, coReady}, {62'b0, 1'b0, 1'b1});
        #1 reset = 1'b0;
        doWiden(32'h3F800000, c);
        drain();

        // Reset while an output is pending
        rdyForce = 1'b0;
        @(negedge clk);
        doWiden(32'hC0000000, c);
        waitValid();
        #2 reset = 1'b1;
        q.delete();
        #1 check("rst_tx", {62'b0, coValid, coReady}, {62'b0, 1'b0, 1'b1});
        #1 reset = 1'b0;
        rdyForce = 1'b1;
        doNarrow(32'h3FF00000, 32'h0, 0, c);
        drain();

        // Randomized mix with random backpressure and input gaps
        rdyRandom = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                int sel = $urandom_range(0, 9);
                logic [7:0]  e8;
                logic [22:0] f23 = 23'($urandom);
                if (sel == 0) e8 = 8'h00;
                else if (sel == 1) e8 = 8'hFF;
                else e8 = 8'($urandom_range(1, 254));
                if (sel == 1 && $urandom_range(0, 1) == 0) f23 = '0;
                doWiden({1'($urandom), e8, f23}, c);
            end else begin
                int          sel = $urandom_range(0, 9);
                logic [10:0] e11;
                logic [51:0] f52 = {20'($urandom), 32'($urandom)};
                if (sel == 0) e11 = 11'd0;
                else if (sel == 1) e11 = 11'h7FF;
                else if (sel == 2) e11 = 11'(896 + $urandom_range(0, 3));
                else if (sel == 3) e11 = 11'(1149 + $urandom_range(0, 3));
                else e11 = 11'(896 + $urandom_range(1, 254));
                if (sel == 1 && $urandom_range(0, 2) == 0) f52 = '0;
                if (sel == 1 && $urandom_range(0, 2) == 0) f52[51:29] = '0;
                if ($urandom_range(0, 3) == 0) f52[28:0] = 29'h10000000;
                if ($urandom_range(0, 3) == 0) f52[51:28] = '1;
                doNarrow({1'($urandom), e11, f52[51:32]}, f52[31:0], $urandom_range(0, 2), c);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire
